// File: rtl/dvp_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module  : dvp_pixel_packer
// Purpose : Packs OV5640 DVP RGB565 bytes (two bytes per pixel, already in the
//           clk domain and qualified by a one-cycle strobe) into 32-bit words
//           of two pixels each and writes them into a synchronous FIFO. Tracks
//           frame/line framing and drops the rest of a frame cleanly when the
//           FIFO overflows.
// Ports   :
//   clk              system clock
//   rest             synchronous active-high reset
//   cam_vsync        DVP vsync, active level VSYNC_POL
//   cam_href         DVP href, high during an active line
//   cam_valid        one-cycle strobe per camera byte
//   cam_data[7:0]    camera byte
//   enable           capture enable, sampled on the vsync edge
//   fifo_full        FIFO full flag
//   fifo_write       FIFO write strobe
//   fifo_write_data  packed word (two pixels)
//   fifo_flush       one-cycle FIFO flush pulse at capture start
//   frame_start      one-cycle pulse, capture of a frame begins
//   frame_done       one-cycle pulse, captured frame ended normally
//   overflow         sticky, a word was lost to a full FIFO
//   line_count[11:0] lines with at least one pixel in the frame (saturating)
// Revision: 1.0 - initial release
// ============================================================================
module dvp_pixel_packer #(
  parameter bit BYTE_SWAP = 1'b0,
  parameter bit SWAP_PIX  = 1'b0,
  parameter bit PAD_ODD   = 1'b1,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rest,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic        cam_valid,
  input  logic [7:0]  cam_data,
  input  logic        enable,
  input  logic        fifo_full,
  output logic        fifo_write,
  output logic [31:0] fifo_write_data,
  output logic        fifo_flush,
  output logic        frame_start,
  output logic        frame_done,
  output logic        overflow,
  output logic [11:0] line_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DROP   = 2'd2
  } state_t;

  state_t      state;
  logic        vsync_q;
  logic        href_q;
  logic        byte_phase;
  logic        pix_phase;
  logic        line_has_pix;
  logic [7:0]  byte_hold;
  logic [15:0] pix_hold;
  logic        word_valid;
  logic [31:0] word_data;

  logic        vs_active;
  logic        vs_edge;
  logic        byte_in;
  logic        line_end;
  logic [15:0] cur_pix;

  assign vs_active = (cam_vsync == VSYNC_POL);
  assign vs_edge   = vs_active && !vsync_q;
  // Bytes are only taken inside an active line of a capturing frame.
  assign byte_in   = (state == S_ACTIVE) && cam_href && cam_valid && !vs_active;
  assign line_end  = href_q && !cam_href;
  // The first byte of a pixel sits in byte_hold; cam_data is the second.
  assign cur_pix   = BYTE_SWAP ? {cam_data, byte_hold} : {byte_hold, cam_data};

  // Write is combinational from the registered word so a full FIFO in the
  // same cycle suppresses it without an extra pipeline stage.
  assign fifo_write      = word_valid && !fifo_full && (state != S_DROP);
  assign fifo_write_data = word_data;

  always_ff @(posedge clk) begin
    if (rest) begin
      state        <= S_IDLE;
      vsync_q      <= 1'b1;   // a vsync already active at reset is not an edge
      href_q       <= 1'b0;
      byte_phase   <= 1'b0;
      pix_phase    <= 1'b0;
      line_has_pix <= 1'b0;
      byte_hold    <= 8'h00;
      pix_hold     <= 16'h0000;
      word_valid   <= 1'b0;
      word_data    <= 32'h0000_0000;
      fifo_flush   <= 1'b0;
      frame_start  <= 1'b0;
      frame_done   <= 1'b0;
      overflow     <= 1'b0;
      line_count   <= 12'd0;
    end else begin
      vsync_q     <= vs_active;
      href_q      <= cam_href;
      fifo_flush  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      word_valid  <= 1'b0;

      // Lost word: remember it and stop capturing until the next frame.
      // A vsync edge in the same cycle takes precedence for the state below.
      if (word_valid && fifo_full && (state != S_DROP)) begin
        overflow <= 1'b1;
        if (state == S_ACTIVE) begin
          state <= S_DROP;
        end
      end

      case (state)
        S_IDLE, S_DROP: begin
          if (vs_edge) begin
            byte_phase   <= 1'b0;
            pix_phase    <= 1'b0;
            line_has_pix <= 1'b0;
            if (enable) begin
              state       <= S_ACTIVE;
              fifo_flush  <= 1'b1;
              frame_start <= 1'b1;
              line_count  <= 12'd0;
            end else begin
              state <= S_IDLE;
            end
          end
        end

        S_ACTIVE: begin
          if (vs_edge) begin
            // Frame boundary: any partial byte/pixel is discarded.
            frame_done   <= 1'b1;
            byte_phase   <= 1'b0;
            pix_phase    <= 1'b0;
            line_has_pix <= 1'b0;
            if (enable) begin
              state       <= S_ACTIVE;
              frame_start <= 1'b1;
              line_count  <= 12'd0;
            end else begin
              state <= S_IDLE;
            end
          end else if (byte_in) begin
            if (!byte_phase) begin
              byte_hold  <= cam_data;
              byte_phase <= 1'b1;
            end else begin
              byte_phase   <= 1'b0;
              line_has_pix <= 1'b1;
              if (!pix_phase) begin
                pix_hold  <= cur_pix;
                pix_phase <= 1'b1;
              end else begin
                pix_phase  <= 1'b0;
                word_valid <= 1'b1;
                word_data  <= SWAP_PIX ? {pix_hold, cur_pix} : {cur_pix, pix_hold};
              end
            end
          end else if (line_end) begin
            // A lone trailing byte is simply forgotten by clearing the phase.
            byte_phase   <= 1'b0;
            pix_phase    <= 1'b0;
            line_has_pix <= 1'b0;
            if (pix_phase && PAD_ODD) begin
              word_valid <= 1'b1;
              word_data  <= SWAP_PIX ? {pix_hold, 16'h0000} : {16'h0000, pix_hold};
            end
            if (line_has_pix && (line_count != 12'hFFF)) begin
              line_count <= line_count + 12'd1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dvp_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module  : tb_dvp_pixel_packer
// Purpose : Self-checking bench for dvp_pixel_packer. Two instances share the
//           stimulus: a_ uses default parameters, b_ uses BYTE_SWAP=1 and
//           PAD_ODD=0. Expected words are queued when a line is driven and
//           compared as the FIFO writes appear.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dvp_pixel_packer;

  logic        clk = 1'b0;
  logic        rest;
  logic        cam_vsync;
  logic        cam_href;
  logic        cam_valid;
  logic [7:0]  cam_data;
  logic        enable;
  logic        fifo_full;

  logic        a_write, a_flush, a_start, a_done, a_ovf;
  logic [31:0] a_data;
  logic [11:0] a_lc;
  logic        b_write, b_flush, b_start, b_done, b_ovf;
  logic [31:0] b_data;
  logic [11:0] b_lc;

  dvp_pixel_packer #(.BYTE_SWAP(1'b0), .SWAP_PIX(1'b0), .PAD_ODD(1'b1), .VSYNC_POL(1'b1)) u_dut_a (
    .clk(clk), .rest(rest), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_valid(cam_valid), .cam_data(cam_data), .enable(enable), .fifo_full(fifo_full),
    .fifo_write(a_write), .fifo_write_data(a_data), .fifo_flush(a_flush),
    .frame_start(a_start), .frame_done(a_done), .overflow(a_ovf), .line_count(a_lc)
  );

  dvp_pixel_packer #(.BYTE_SWAP(1'b1), .SWAP_PIX(1'b0), .PAD_ODD(1'b0), .VSYNC_POL(1'b1)) u_dut_b (
    .clk(clk), .rest(rest), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_valid(cam_valid), .cam_data(cam_data), .enable(enable), .fifo_full(fifo_full),
    .fifo_write(b_write), .fifo_write_data(b_data), .fifo_flush(b_flush),
    .frame_start(b_start), .frame_done(b_done), .overflow(b_ovf), .line_count(b_lc)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic [31:0] exp_a, exp_b;
  int          flush_cnt = 0, start_cnt = 0, done_cnt = 0;
  logic [7:0]  pat [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write must match the oldest expected word.
  always @(negedge clk) begin
    if (a_write) begin
      if (q_a.size() == 0) check("a_wr_unexpected", a_data, 32'hFFFF_FFFF ^ a_data);
      else begin
        exp_a = q_a.pop_front();
        check("a_wr_data", a_data, exp_a);
      end
    end
    if (b_write) begin
      if (q_b.size() == 0) check("b_wr_unexpected", b_data, 32'hFFFF_FFFF ^ b_data);
      else begin
        exp_b = q_b.pop_front();
        check("b_wr_data", b_data, exp_b);
      end
    end
    if (a_flush) flush_cnt++;
    if (a_start) start_cnt++;
    if (a_done)  done_cnt++;
  end

  task automatic send_byte(input logic [7:0] d);
    cam_data  = d;
    cam_valid = 1'b1;
    @(posedge clk); #1;
    cam_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Drives n bytes of pat as one line. fifo_full rises before byte full_idx.
  // Words completed before full_idx are expected when exp_on is set.
  task automatic send_line(input int n, input int full_idx, input bit exp_on);
    logic [15:0] p0, p1;
    int npix;
    if (exp_on) begin
      for (int w = 0; 4*w+3 < n; w++) begin
        if (4*w+3 < full_idx) begin
          p0 = {pat[4*w],   pat[4*w+1]};
          p1 = {pat[4*w+2], pat[4*w+3]};
          q_a.push_back({p1, p0});
          q_b.push_back({pat[4*w+3], pat[4*w+2], pat[4*w+1], pat[4*w]});
        end
      end
      npix = n / 2;
      if ((npix % 2) == 1) begin
        q_a.push_back({16'h0000, pat[2*(npix-1)], pat[2*(npix-1)+1]});
      end
    end
    @(posedge clk); #1;
    cam_href = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i == full_idx) fifo_full = 1'b1;
      send_byte(pat[i]);
    end
    cam_href = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    fifo_full = 1'b0;
  endtask

  task automatic vsync_pulse();
    @(posedge clk); #1;
    cam_vsync = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cam_vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    pat = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    rest = 1'b1; cam_vsync = 1'b0; cam_href = 1'b0; cam_valid = 1'b0;
    cam_data = 8'h00; enable = 1'b1; fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_write", {31'd0, a_write}, 32'd0);
    check("rst_flush", {31'd0, a_flush}, 32'd0);
    check("rst_start", {31'd0, a_start}, 32'd0);
    check("rst_ovf",   {31'd0, a_ovf},   32'd0);
    check("rst_lc",    {20'd0, a_lc},    32'd0);
    rest = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Frame start from IDLE, one full line.
    vsync_pulse();
    check("t1_flush", flush_cnt, 1);
    check("t1_start", start_cnt, 1);
    check("t1_done",  done_cnt,  0);
    send_line(8, 99, 1'b1);
    check("t1_lc", {20'd0, a_lc}, 32'd1);

    // Three-pixel line: padded on a, discarded on b.
    send_line(6, 99, 1'b1);
    check("t2_lc_a", {20'd0, a_lc}, 32'd2);
    check("t2_lc_b", {20'd0, b_lc}, 32'd2);

    // Five bytes: trailing byte dropped, next line starts clean.
    send_line(5, 99, 1'b1);
    send_line(8, 99, 1'b1);
    check("t5_lc", {20'd0, a_lc}, 32'd4);

    // Vsync while active with enable: done + start, no flush.
    vsync_pulse();
    check("t4_done",  done_cnt,  1);
    check("t4_start", start_cnt, 2);
    check("t4_flush", flush_cnt, 1);
    check("t4_lc",    {20'd0, a_lc}, 32'd0);

    // FIFO full on the second word: drop rest of frame.
    send_line(8, 4, 1'b1);
    check("t3_ovf_a", {31'd0, a_ovf}, 32'd1);
    check("t3_ovf_b", {31'd0, b_ovf}, 32'd1);
    send_line(8, 99, 1'b0);
    vsync_pulse();
    check("t3_flush", flush_cnt, 2);
    check("t3_start", start_cnt, 3);
    check("t3_done",  done_cnt,  1);
    check("t3_ovf_sticky", {31'd0, a_ovf}, 32'd1);
    send_line(6, 99, 1'b1);
    check("t3_lc", {20'd0, a_lc}, 32'd1);

    // Disable: frame ends normally, then an idle vsync does nothing.
    enable = 1'b0;
    vsync_pulse();
    check("t4b_done",  done_cnt,  2);
    check("t4b_start", start_cnt, 3);
    vsync_pulse();
    check("t4b_flush", flush_cnt, 2);
    send_line(8, 99, 1'b0);

    // Reset in the middle of a line.
    enable = 1'b1;
    vsync_pulse();
    check("t6_flush", flush_cnt, 3);
    cam_href = 1'b1;
    for (int i = 0; i < 3; i++) send_byte(pat[i]);
    rest = 1'b1;
    @(posedge clk); #1;
    check("t6_ovf",   {31'd0, a_ovf},   32'd0);
    check("t6_lc",    {20'd0, a_lc},    32'd0);
    check("t6_write", {31'd0, a_write}, 32'd0);
    check("t6_start", {31'd0, a_start}, 32'd0);
    check("t6_done",  {31'd0, a_done},  32'd0);
    rest = 1'b0;
    for (int i = 3; i < 8; i++) send_byte(pat[i]);
    cam_href = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t6_idle_flush", flush_cnt, 3);
    vsync_pulse();
    check("t6_flush2", flush_cnt, 4);
    send_line(8, 99, 1'b1);
    check("t6_lc2", {20'd0, a_lc}, 32'd1);

    repeat (4) @(posedge clk);
    #1;
    check("q_a_left", q_a.size(), 0);
    check("q_b_left", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
